// File: rtl/aes_input_loader.sv
// Byte-serial key/text collector in front of AES_TOP: assembles Key/InTxt, issues a
// one-cycle KeyValid, then holds the inputs until both encryption and decryption finish.
module aes_input_loader #(
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   key_len,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         EncFinish,
    input  logic         DecFinish,
    output logic         KeyValid,
    output logic [0:255] Key,
    output logic [0:127] InTxt,
    output logic [3:0]   Nk,
    output logic [3:0]   Nr,
    output logic         busy,
    output logic         frame_done,
    output logic         timeout,
    output logic         cfg_err
);

    typedef enum logic [2:0] {
        IDLE, LOAD_KEY, LOAD_TXT, ISSUE, WAIT_ENC, WAIT_DEC
    } state_t;

    // Expiry is decided in the cycle the count steps to TIMEOUT-1, so the registered
    // timeout pulse lands exactly TIMEOUT cycles after KeyValid.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 2);

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [15:0] wd_reg;
    logic [7:0]  key_mem [32];
    logic [7:0]  txt_mem [16];
    logic [3:0]  nk_reg, nr_reg;
    logic        enc_q, dec_q;
    logic        kv_reg, done_reg, to_reg, cfg_err_reg;
    logic        accept, enc_rise, dec_rise, wd_expire;
    logic        done_next, to_next;
    logic [4:0]  key_last;

    assign in_ready  = (state_reg == IDLE) || (state_reg == LOAD_KEY) || (state_reg == LOAD_TXT);
    assign busy      = (state_reg != IDLE);
    assign accept    = in_valid & in_ready;
    assign enc_rise  = EncFinish & ~enc_q;
    assign dec_rise  = DecFinish & ~dec_q;
    assign wd_expire = (wd_reg >= WD_LAST);
    assign key_last  = 5'({nk_reg, 2'b00} - 6'd1);

    assign KeyValid   = kv_reg;
    assign frame_done = done_reg;
    assign timeout    = to_reg;
    assign cfg_err    = cfg_err_reg;
    assign Nk         = nk_reg;
    assign Nr         = nr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_key
            assign Key[gi*8 +: 8] = key_mem[gi];
        end
        for (gi = 0; gi < 16; gi++) begin : g_txt
            assign InTxt[gi*8 +: 8] = txt_mem[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        to_next    = 1'b0;
        case (state_reg)
            IDLE:     if (accept) state_next = LOAD_KEY;
            LOAD_KEY: if (accept && cnt_reg == key_last) state_next = LOAD_TXT;
            LOAD_TXT: if (accept && cnt_reg == 5'd15) state_next = ISSUE;
            ISSUE:    state_next = WAIT_ENC;
            WAIT_ENC: begin
                if (enc_rise && dec_rise) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (enc_rise) begin
                    state_next = WAIT_DEC;
                end else if (wd_expire) begin
                    state_next = IDLE;
                    to_next    = 1'b1;
                end
            end
            WAIT_DEC: begin
                if (dec_rise) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (wd_expire) begin
                    state_next = IDLE;
                    to_next    = 1'b1;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            kv_reg    <= 1'b0;
            done_reg  <= 1'b0;
            to_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            kv_reg    <= (state_next == ISSUE);
            done_reg  <= done_next;
            to_reg    <= to_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) key_mem[i] <= '0;
            for (int i = 0; i < 16; i++) txt_mem[i] <= '0;
            cnt_reg     <= '0;
            wd_reg      <= '0;
            nk_reg      <= '0;
            nr_reg      <= '0;
            cfg_err_reg <= 1'b0;
            enc_q       <= 1'b0;
            dec_q       <= 1'b0;
        end else begin
            enc_q <= EncFinish;
            dec_q <= DecFinish;
            case (state_reg)
                IDLE: if (accept) begin
                    // New frame: wipe the previous key/text so unused key bytes read zero.
                    for (int i = 0; i < 32; i++) key_mem[i] <= '0;
                    for (int i = 0; i < 16; i++) txt_mem[i] <= '0;
                    key_mem[0] <= in_byte;
                    cnt_reg    <= 5'd1;
                    case (key_len)
                        2'b01:   begin nk_reg <= 4'd6; nr_reg <= 4'd12; end
                        2'b10:   begin nk_reg <= 4'd8; nr_reg <= 4'd14; end
                        default: begin nk_reg <= 4'd4; nr_reg <= 4'd10; end
                    endcase
                    if (key_len == 2'b11) cfg_err_reg <= 1'b1;
                end
                LOAD_KEY: if (accept) begin
                    key_mem[cnt_reg] <= in_byte;
                    cnt_reg <= (cnt_reg == key_last) ? 5'd0 : cnt_reg + 5'd1;
                end
                LOAD_TXT: if (accept) begin
                    txt_mem[cnt_reg[3:0]] <= in_byte;
                    cnt_reg <= (cnt_reg == 5'd15) ? 5'd0 : cnt_reg + 5'd1;
                end
                ISSUE:              wd_reg <= '0;
                WAIT_ENC, WAIT_DEC: wd_reg <= wd_reg + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_input_loader.sv
// Directed testbench for aes_input_loader: instance a uses the default watchdog,
// instance b uses TIMEOUT = 16 for the watchdog scenarios.
module tb_aes_input_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   key_len;
    logic [7:0]   in_byte;
    logic         valid_a, valid_b, enc_a, dec_a, enc_b, dec_b;
    logic         ready_a, kv_a, busy_a, done_a, to_a, err_a;
    logic         ready_b, kv_b, busy_b, done_b, to_b, err_b;
    logic [0:255] key_a, key_b;
    logic [0:127] txt_a, txt_b;
    logic [3:0]   nk_a, nr_a, nk_b, nr_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [0:255] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:255] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [0:255] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] TXT    = 128'h00112233445566778899aabbccddeeff;

    aes_input_loader #(.TIMEOUT(4096)) dut_a (
        .clk(clk), .rst(rst), .key_len(key_len), .in_byte(in_byte), .in_valid(valid_a),
        .in_ready(ready_a), .EncFinish(enc_a), .DecFinish(dec_a), .KeyValid(kv_a),
        .Key(key_a), .InTxt(txt_a), .Nk(nk_a), .Nr(nr_a), .busy(busy_a),
        .frame_done(done_a), .timeout(to_a), .cfg_err(err_a)
    );

    aes_input_loader #(.TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .key_len(key_len), .in_byte(in_byte), .in_valid(valid_b),
        .in_ready(ready_b), .EncFinish(enc_b), .DecFinish(dec_b), .KeyValid(kv_b),
        .Key(key_b), .InTxt(txt_b), .Nk(nk_b), .Nr(nr_b), .busy(busy_b),
        .frame_done(done_b), .timeout(to_b), .cfg_err(err_b)
    );

    task automatic send(input bit sel, input logic [7:0] b, input bit gaps);
        int t;
        int unsigned gap;
        if (gaps) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
        in_byte = b;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        t = 0;
        while (!(sel ? ready_b : ready_a) && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send_handshake: in_ready stayed %b, required 1", sel ? ready_b : ready_a);
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    // Key bytes are 00,01,..; text bytes are 00,11,22,..,ff. key_len is scrambled after
    // the first byte to show it is only sampled at frame start.
    task automatic load_frame(input bit sel, input logic [1:0] kl, input int nkey,
                              input bit gaps, output int cycles);
        int start;
        key_len = kl;
        start = cyc;
        for (int i = 0; i < nkey + 16; i++) begin
            if (i < nkey) send(sel, 8'(i), gaps);
            else          send(sel, 8'((i - nkey) * 17), gaps);
            if (i == 0) key_len = ~kl;
        end
        cycles = cyc - start;
    endtask

    task automatic finish_a();
        int t;
        enc_a = 1'b0; dec_a = 1'b0;
        @(posedge clk); #1;
        enc_a = 1'b1;
        @(posedge clk); #1;
        dec_a = 1'b1;
        t = 0;
        while (done_a !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL finish_frame_done: got %b required 1", done_a); end
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL finish_in_ready: got %b required 1", ready_a); end
        enc_a = 1'b0; dec_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_len = 2'b00; in_byte = 8'h00;
        valid_a = 0; valid_b = 0; enc_a = 0; dec_a = 0; enc_b = 0; dec_b = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", ready_a); end
        n_checks++; if (kv_a !== 1'b0) begin n_fail++; $display("FAIL reset_keyvalid: got %b required 0", kv_a); end
        n_checks++; if (key_a !== '0) begin n_fail++; $display("FAIL reset_key: got %h required 0", key_a); end
        n_checks++; if (txt_a !== '0) begin n_fail++; $display("FAIL reset_intxt: got %h required 0", txt_a); end
        n_checks++; if (nk_a !== 4'd0 || nr_a !== 4'd0) begin n_fail++; $display("FAIL reset_nk_nr: got %0d/%0d required 0/0", nk_a, nr_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_a); end
        n_checks++; if (done_a !== 1'b0 || to_a !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b timeout=%b required 0/0", done_a, to_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b required 0", err_a); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_aes128();
        int cycles;
        enc_a = 1'b1;  // stale level left high before the frame is issued
        load_frame(1'b0, 2'b00, 16, 1'b0, cycles);
        n_checks++; if (cycles != 32) begin n_fail++; $display("FAIL aes128_frame_cycles: got %0d required 32", cycles); end
        n_checks++; if (kv_a !== 1'b1) begin n_fail++; $display("FAIL aes128_keyvalid: got %b required 1", kv_a); end
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL aes128_in_ready: got %b required 0", ready_a); end
        n_checks++; if (key_a !== KEY128) begin n_fail++; $display("FAIL aes128_key: got %h required %h", key_a, KEY128); end
        n_checks++; if (txt_a !== TXT) begin n_fail++; $display("FAIL aes128_intxt: got %h required %h", txt_a, TXT); end
        n_checks++; if (nk_a !== 4'd4 || nr_a !== 4'd10) begin n_fail++; $display("FAIL aes128_nk_nr: got %0d/%0d required 4/10", nk_a, nr_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL aes128_cfg_err: got %b required 0", err_a); end
    endtask

    // Continues from the KeyValid cycle of test_aes128.
    task automatic test_completion();
        for (int k = 1; k <= 62; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                n_checks++; if (kv_a !== 1'b0) begin n_fail++; $display("FAIL completion_keyvalid_width: got %b required 0", kv_a); end
            end
            n_checks++; if (done_a !== (k == 61)) begin n_fail++; $display("FAIL completion_frame_done k=%0d: got %b required %b", k, done_a, k == 61); end
            n_checks++; if (busy_a !== (k < 61)) begin n_fail++; $display("FAIL completion_busy k=%0d: got %b required %b", k, busy_a, k < 61); end
            n_checks++; if (ready_a !== (k >= 61)) begin n_fail++; $display("FAIL completion_in_ready k=%0d: got %b required %b", k, ready_a, k >= 61); end
            n_checks++; if (key_a !== KEY128 || txt_a !== TXT) begin n_fail++; $display("FAIL completion_stable k=%0d: got %h/%h required %h/%h", k, key_a, txt_a, KEY128, TXT); end
            n_checks++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL completion_timeout k=%0d: got %b required 0", k, to_a); end
            if (k == 5)  enc_a = 1'b0;
            if (k == 10) dec_a = 1'b1;  // lone DecFinish while waiting for encryption: ignored
            if (k == 11) dec_a = 1'b0;
            if (k == 30) enc_a = 1'b1;
            if (k == 60) dec_a = 1'b1;
        end
        enc_a = 1'b0; dec_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_aes256_gaps();
        int cycles;
        load_frame(1'b0, 2'b10, 32, 1'b1, cycles);
        n_checks++; if (kv_a !== 1'b1) begin n_fail++; $display("FAIL aes256_keyvalid: got %b required 1", kv_a); end
        n_checks++; if (nk_a !== 4'd8 || nr_a !== 4'd14) begin n_fail++; $display("FAIL aes256_nk_nr: got %0d/%0d required 8/14", nk_a, nr_a); end
        n_checks++; if (key_a !== KEY256) begin n_fail++; $display("FAIL aes256_key: got %h required %h", key_a, KEY256); end
        n_checks++; if (txt_a !== TXT) begin n_fail++; $display("FAIL aes256_intxt: got %h required %h", txt_a, TXT); end
        in_byte = 8'hee;
        valid_a = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready k=%0d: got %b required 0", k, ready_a); end
            @(posedge clk); #1;
            n_checks++; if (kv_a !== 1'b0) begin n_fail++; $display("FAIL busy_keyvalid k=%0d: got %b required 0", k, kv_a); end
        end
        valid_a = 1'b0;
        n_checks++; if (key_a !== KEY256 || txt_a !== TXT) begin n_fail++; $display("FAIL busy_bytes_consumed: got %h/%h required %h/%h", key_a, txt_a, KEY256, TXT); end
        finish_a();
    endtask

    task automatic test_watchdog();
        int cycles;
        load_frame(1'b1, 2'b00, 16, 1'b0, cycles);
        n_checks++; if (kv_b !== 1'b1) begin n_fail++; $display("FAIL wd_keyvalid: got %b required 1", kv_b); end
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            n_checks++; if (to_b !== (k == 16)) begin n_fail++; $display("FAIL wd_timeout k=%0d: got %b required %b", k, to_b, k == 16); end
            n_checks++; if (busy_b !== (k < 16)) begin n_fail++; $display("FAIL wd_busy k=%0d: got %b required %b", k, busy_b, k < 16); end
            n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL wd_frame_done k=%0d: got %b required 0", k, done_b); end
        end
        load_frame(1'b1, 2'b00, 16, 1'b0, cycles);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            n_checks++; if (done_b !== (k == 16)) begin n_fail++; $display("FAIL wd_race_frame_done k=%0d: got %b required %b", k, done_b, k == 16); end
            n_checks++; if (to_b !== 1'b0) begin n_fail++; $display("FAIL wd_race_timeout k=%0d: got %b required 0", k, to_b); end
            n_checks++; if (busy_b !== (k < 16)) begin n_fail++; $display("FAIL wd_race_busy k=%0d: got %b required %b", k, busy_b, k < 16); end
            if (k == 5)  enc_b = 1'b1;
            if (k == 15) dec_b = 1'b1;  // DecFinish rises in the expiry cycle
        end
        enc_b = 1'b0; dec_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cycles;
        key_len = 2'b01;
        for (int i = 0; i < 10; i++) send(1'b0, 8'(i + 8'h40), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ready_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_busy: got %b/%b required 1/0", ready_a, busy_a); end
        n_checks++; if (key_a !== '0 || txt_a !== '0) begin n_fail++; $display("FAIL midrst_data: got %h/%h required 0/0", key_a, txt_a); end
        n_checks++; if (nk_a !== 4'd0 || nr_a !== 4'd0) begin n_fail++; $display("FAIL midrst_nk_nr: got %0d/%0d required 0/0", nk_a, nr_a); end
        n_checks++; if (kv_a !== 1'b0 || done_a !== 1'b0 || to_a !== 1'b0 || err_a !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got kv=%b done=%b to=%b err=%b required 0", kv_a, done_a, to_a, err_a); end
        rst = 1'b0;
        load_frame(1'b0, 2'b01, 24, 1'b0, cycles);
        n_checks++; if (cycles != 40) begin n_fail++; $display("FAIL aes192_frame_cycles: got %0d required 40", cycles); end
        n_checks++; if (kv_a !== 1'b1) begin n_fail++; $display("FAIL aes192_keyvalid: got %b required 1", kv_a); end
        n_checks++; if (nk_a !== 4'd6 || nr_a !== 4'd12) begin n_fail++; $display("FAIL aes192_nk_nr: got %0d/%0d required 6/12", nk_a, nr_a); end
        n_checks++; if (key_a !== KEY192) begin n_fail++; $display("FAIL aes192_key: got %h required %h", key_a, KEY192); end
        n_checks++; if (key_a[192:255] !== 64'h0) begin n_fail++; $display("FAIL aes192_key_tail: got %h required 0", key_a[192:255]); end
        n_checks++; if (txt_a !== TXT) begin n_fail++; $display("FAIL aes192_intxt: got %h required %h", txt_a, TXT); end
        finish_a();
    endtask

    task automatic test_cfg_err();
        int cycles;
        load_frame(1'b0, 2'b11, 16, 1'b0, cycles);
        n_checks++; if (cycles != 32) begin n_fail++; $display("FAIL cfg_frame_cycles: got %0d required 32", cycles); end
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL cfg_err_set: got %b required 1", err_a); end
        n_checks++; if (nk_a !== 4'd4 || nr_a !== 4'd10) begin n_fail++; $display("FAIL cfg_nk_nr: got %0d/%0d required 4/10", nk_a, nr_a); end
        n_checks++; if (key_a !== KEY128 || kv_a !== 1'b1) begin n_fail++; $display("FAIL cfg_key: got %h kv=%b required %h kv=1", key_a, kv_a, KEY128); end
        finish_a();
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL cfg_err_sticky: got %b required 1", err_a); end
    endtask

    // Called in the frame_done cycle: the next frame's first byte must go in at the next edge.
    task automatic test_back_to_back();
        int start;
        key_len = 2'b00;
        start = cyc;
        send(1'b0, 8'h5a, 1'b0);
        n_checks++; if (cyc - start != 1) begin n_fail++; $display("FAIL b2b_accept_latency: got %0d required 1", cyc - start); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b required 1", busy_a); end
        n_checks++; if (key_a !== {8'h5a, 248'h0} || txt_a !== '0) begin n_fail++; $display("FAIL b2b_clear: got %h/%h required 5a00..0/0", key_a, txt_a); end
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL b2b_cfg_err: got %b required 1", err_a); end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not end, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_aes128();
        test_completion();
        test_aes256_gaps();
        test_watchdog();
        test_reset_mid();
        test_cfg_err();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_input_loader.md
# aes_input_loader

Byte-serial front end that sits directly upstream of `AES_TOP`. It collects a key (16, 24 or 32 bytes) followed by a 16-byte text block from an 8-bit valid/ready stream. It drives `AES_TOP` with `Key`, `InTxt`, `Nk`, `Nr` and a one-cycle `KeyValid`. It then holds those inputs stable until `AES_TOP` reports completion of both the encryption pass and the decryption pass.

## Interface
- `TIMEOUT`, default 4096: max cycles to wait for `EncFinish` and then `DecFinish` after `KeyValid`. Legal range is 2..65535.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_len` in 2: key size, where 00 = 128, 01 = 192, 10 = 256, and 11 is reserved. Sampled only with the first accepted byte of a frame.
- `in_byte` in 8: stream data.
- `in_valid` in 1: stream data valid.
- `in_ready` out 1: loader can accept a byte.
- `EncFinish` in 1: from `AES_TOP`; only the rising edge is used.
- `DecFinish` in 1: from `AES_TOP`; only the rising edge is used.
- `KeyValid` out 1: one-cycle start pulse to `AES_TOP`.
- `Key` out [0:255]: key, first byte in `Key[0:7]`; bytes beyond Nk*4 are zero.
- `InTxt` out [0:127]: text block, first text byte in `InTxt[0:7]`.
- `Nk` out 4: 4, 6 or 8.
- `Nr` out 4: 10, 12 or 14.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_done` out 1: one-cycle pulse on normal completion.
- `timeout` out 1: one-cycle pulse on watchdog expiry.
- `cfg_err` out 1: sticky flag, set when reserved `key_len` is seen; cleared only by `rst`.

## Operation
- **Handshake.** A byte transfers on a rising edge where `in_valid & in_ready` is high. `in_ready` is high only in IDLE, LOAD_KEY and LOAD_TXT.
- **Byte order.** Key bytes arrive first, then 16 text bytes.
- **Byte placement.** Byte k of the key goes to `Key[8k:8k+7]`. Byte k of the text goes to `InTxt[8k:8k+7]`.
- **Key size mapping.**
  - `key_len` 00: Nk = 4, Nr = 10.
  - `key_len` 01: Nk = 6, Nr = 12.
  - `key_len` 10: Nk = 8, Nr = 14.
  - `key_len` 11: Nk = 4, Nr = 10, and `cfg_err` is set.
- **Byte counter.** 5-bit counter `cnt`.
- **States:**
  - **IDLE.** On the first accepted byte:
    - clear all of `Key` and `InTxt`;
    - write the byte to `Key[0:7]`;
    - latch `Nk`/`Nr` from `key_len`;
    - set cnt = 1 and go to LOAD_KEY.
  - **LOAD_KEY.** Each accepted byte goes to key slot cnt, then cnt increments. When the byte accepted is slot Nk*4−1, set cnt = 0 and go to LOAD_TXT.
  - **LOAD_TXT.** Each accepted byte goes to text slot cnt. When the byte accepted is slot 15, go to ISSUE.
  - **ISSUE.** `KeyValid` = 1 for exactly this cycle. Clear the watchdog, then go to WAIT_ENC.
  - **WAIT_ENC.**
    - On an `EncFinish` rising edge, go to WAIT_DEC.
    - If `EncFinish` and `DecFinish` rise in the same cycle, go straight to IDLE with `frame_done`.
  - **WAIT_DEC.** On a `DecFinish` rising edge, go to IDLE and pulse `frame_done`.
- **Edge detection.** Registered copies `enc_q`/`dec_q` (reset 0). A rise is `sig & ~sig_q`. A `Finish` level left high from a previous frame does not advance the FSM.
- **Watchdog.** Counts cycles in WAIT_ENC and WAIT_DEC. It is not reset between the two states. When it reaches TIMEOUT−1 with no qualifying edge, the FSM pulses `timeout` and goes to IDLE. If a qualifying edge arrives in the same cycle, the edge wins and no `timeout` is raised.
- **Output stability.** `Key`, `InTxt`, `Nk` and `Nr` do not change from ISSUE until the next frame's first byte. The last values are retained through IDLE.

## Timing
- **Reset values.** All outputs are 0, including `Nk`, `Nr`, `KeyValid`, `frame_done`, `timeout`, `cfg_err` and `busy`, except `in_ready` = 1. State is IDLE and cnt = 0.
- **Reset mid-operation.** Applies the same reset values on the next edge, from any state. A partial frame is discarded.
- **Start latency.** The last text byte is accepted at edge N. `KeyValid` is high in cycle N..N+1 (registered). `in_ready` drops in the same cycle.
- **Minimum frame length** (`in_valid` held high): 32 cycles for AES-128, 40 for AES-192, 48 for AES-256, each followed by `KeyValid` one cycle later.
- **Completion latency.**
  - `frame_done` goes high in the cycle after the edge that samples the `DecFinish` rise.
  - `in_ready` returns high in that same cycle.
  - A new frame's first byte can be accepted at the next edge.
- **Stall behaviour.** Gaps in `in_valid` stall the counter with no data loss.
- **Bytes during busy.** Bytes offered while `in_ready` = 0 are not consumed.

## Test plan
- **AES-128 load.**
  - Stimulus: `key_len` = 00; bytes 00..0f, then 00 11 22 … ff, with `in_valid` held high.
  - Required: one-cycle `KeyValid` after the 32nd byte; `Key[0:127]` = 000102…0f and `Key[128:255]` = 0; `InTxt` = 00112233445566778899aabbccddeeff; Nk = 4, Nr = 10.
- **AES-256 load with gaps.**
  - Stimulus: `key_len` = 10; bytes 00..1f, then 16 text bytes, with random `in_valid` gaps.
  - Required: Nk = 8, Nr = 14; `Key` = 00..1f; `KeyValid` after the 48th accepted byte; `in_ready` = 0 from ISSUE until completion.
- **Completion handshake.**
  - Stimulus: `EncFinish` already high before ISSUE; stub drops it, then raises it 30 cycles after `KeyValid`; `DecFinish` rises at 60 cycles.
  - Required: no advance on the stale high level; `frame_done` pulses one cycle after the `DecFinish` rise; `Key`/`InTxt` stable throughout.
- **Watchdog.**
  - Stimulus: TIMEOUT = 16; no `Finish` edges.
  - Required: `timeout` pulses 16 cycles after `KeyValid`; `busy` drops; `frame_done` stays 0. Then repeat with `DecFinish` rising on the expiry cycle: `frame_done` = 1 and `timeout` = 0.
- **Reset and reserved configuration.**
  - Stimulus: `rst` asserted after 10 key bytes.
  - Required: all outputs at their reset values next cycle; a following AES-192 frame (`key_len` = 01) yields Nk = 6, Nr = 12, `Key[192:255]` = 0.
  - Stimulus: then a frame with `key_len` = 11.
  - Required: `cfg_err` = 1 and stays set; frame processed as AES-128.
